rsz_avr_engine: RTL and testbench

RSZ_AVR_ENGINE -- requirements
Module: rsz_avr_engine

---
 rtl/rsz_avr_engine.sv | 147 ++++++++++++++
 tb/tb_rsz_avr_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rsz_avr_engine.sv
// Resize averaging engine: divides an accumulated block sum by the block pixel count
// using a serial restoring divider, saturating to the pixel width. Optional macro: RSZ_AVR_ROUND_EN.
module rsz_avr_engine #(
  parameter int SUM_W    = 22,
  parameter int SZ_W     = 15,
  parameter int PXL_W    = 8,
  parameter int CELL_NUM = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sum_vld,
  output logic                        sum_rdy,
  input  logic [SUM_W-1:0]            sum_data,
  input  logic [SZ_W-1:0]             blk_sz,
  output logic                        pxl_vld,
  input  logic                        pxl_rdy,
  output logic [PXL_W-1:0]            pxl_data,
  output logic [$clog2(CELL_NUM)-1:0] pxl_idx,
  output logic                        pxl_last,
  output logic                        dz_err
);

  localparam int IDX_W = $clog2(CELL_NUM);
`ifdef RSZ_AVR_ROUND_EN
  localparam int DIV_W = SUM_W + 1;
`else
  localparam int DIV_W = SUM_W;
`endif
  localparam int CNT_W = $clog2(DIV_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    OUT
  } stateT;

  stateT state;
  stateT nextState;

  logic              rdyEn;
  logic [DIV_W-1:0]  quo;
  logic [SZ_W-1:0]   divisor;
  logic [SZ_W:0]     rem;
  logic [CNT_W-1:0]  cnt;
  logic [DIV_W-1:0]  dividendIn;
  logic [SZ_W:0]     remShift;
  logic [SZ_W:0]     remDiff;
  logic              qBit;
  logic              divDone;
  logic              saturate;
  logic              sumXfer;

`ifdef RSZ_AVR_ROUND_EN
  // Adding half the divisor before truncating division gives round-half-up.
  assign dividendIn = {1'b0, sum_data} + {{(DIV_W - SZ_W + 1){1'b0}}, blk_sz[SZ_W-1:1]};
`else
  assign dividendIn = sum_data;
`endif

  assign sum_rdy  = rdyEn && (state == IDLE);
  assign pxl_vld  = (state == OUT);
  assign pxl_last = pxl_vld && (pxl_idx == IDX_W'(CELL_NUM - 1));
  assign sumXfer  = sum_vld && sum_rdy;

  // One restoring step: the quotient register shifts dividend bits out of its MSB.
  assign remShift = {rem[SZ_W-1:0], quo[DIV_W-1]};
  assign remDiff  = remShift - {1'b0, divisor};
  assign qBit     = (remShift >= {1'b0, divisor});
  assign divDone  = (state == DIV) && (cnt == CNT_W'(DIV_W));
  assign saturate = (quo[DIV_W-1:PXL_W] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (sumXfer) begin
          nextState = (blk_sz == '0) ? OUT : DIV;
        end
      end
      DIV: begin
        if (divDone) begin
          nextState = OUT;
        end
      end
      OUT: begin
        if (pxl_rdy) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // The extra DIV cycle at cnt==DIV_W registers the saturated result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdyEn    <= 1'b0;
      quo      <= '0;
      divisor  <= '0;
      rem      <= '0;
      cnt      <= '0;
      pxl_data <= '0;
      pxl_idx  <= '0;
      dz_err   <= 1'b0;
    end else begin
      rdyEn <= 1'b1;
      case (state)
        IDLE: begin
          if (sumXfer) begin
            quo     <= dividendIn;
            divisor <= blk_sz;
            rem     <= '0;
            cnt     <= '0;
            if (blk_sz == '0) begin
              pxl_data <= '1;
              dz_err   <= 1'b1;
            end
          end
        end
        DIV: begin
          if (divDone) begin
            pxl_data <= saturate ? '1 : quo[PXL_W-1:0];
          end else begin
            rem <= qBit ? remDiff : remShift;
            quo <= {quo[DIV_W-2:0], qBit};
            cnt <= cnt + CNT_W'(1);
          end
        end
        OUT: begin
          if (pxl_rdy) begin
            pxl_idx <= (pxl_idx == IDX_W'(CELL_NUM - 1)) ? '0 : pxl_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsz_avr_engine.sv
// Directed self-checking bench for rsz_avr_engine (default parameters).
module tb_rsz_avr_engine;

`ifdef RSZ_AVR_ROUND_EN
  localparam int EXP_LAT = 24;
  localparam bit ROUND = 1'b1;
`else
  localparam int EXP_LAT = 23;
  localparam bit ROUND = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        sum_vld;
  logic        sum_rdy;
  logic [21:0] sum_data;
  logic [14:0] blk_sz;
  logic        pxl_vld;
  logic        pxl_rdy;
  logic [7:0]  pxl_data;
  logic [5:0]  pxl_idx;
  logic        pxl_last;
  logic        dz_err;

  int checks = 0;
  int fails  = 0;
  int expIdx = 0;

  rsz_avr_engine dut (
    .clk(clk),
    .rst_n(rst_n),
    .sum_vld(sum_vld),
    .sum_rdy(sum_rdy),
    .sum_data(sum_data),
    .blk_sz(blk_sz),
    .pxl_vld(pxl_vld),
    .pxl_rdy(pxl_rdy),
    .pxl_data(pxl_data),
    .pxl_idx(pxl_idx),
    .pxl_last(pxl_last),
    .dz_err(dz_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic doHandshake(input logic [21:0] s, input logic [14:0] z, output bit ok);
    int n;
    sum_data = s;
    blk_sz   = z;
    sum_vld  = 1'b1;
    n = 0;
    while (!sum_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    ok = sum_rdy;
    @(posedge clk); #1;
    sum_vld = 1'b0;
  endtask

  task automatic waitPixel(output int lat, output bit ok);
    lat = 0;
    while (!pxl_vld && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = pxl_vld;
  endtask

  task automatic takePixel();
    pxl_rdy = 1'b1;
    @(posedge clk); #1;
    pxl_rdy = 1'b0;
    expIdx = (expIdx + 1) % 64;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    expIdx = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sum_vld = 1'b0; pxl_rdy = 1'b0; sum_data = '0; blk_sz = '0;
    #2;
    checks++; if (sum_rdy !== 1'b0) begin fails++; $display("[TB] FAIL rst_sum_rdy: got %b expected 0", sum_rdy); end
    checks++; if (pxl_vld !== 1'b0) begin fails++; $display("[TB] FAIL rst_pxl_vld: got %b expected 0", pxl_vld); end
    checks++; if (pxl_data !== 8'd0) begin fails++; $display("[TB] FAIL rst_pxl_data: got %0d expected 0", pxl_data); end
    checks++; if (pxl_idx !== 6'd0) begin fails++; $display("[TB] FAIL rst_pxl_idx: got %0d expected 0", pxl_idx); end
    checks++; if (pxl_last !== 1'b0) begin fails++; $display("[TB] FAIL rst_pxl_last: got %b expected 0", pxl_last); end
    checks++; if (dz_err !== 1'b0) begin fails++; $display("[TB] FAIL rst_dz_err: got %b expected 0", dz_err); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    checks++; if (sum_rdy !== 1'b0) begin fails++; $display("[TB] FAIL rst_rdy_before_edge: got %b expected 0", sum_rdy); end
    @(posedge clk); #1;
    checks++; if (sum_rdy !== 1'b1) begin fails++; $display("[TB] FAIL rst_rdy_after_edge: got %b expected 1", sum_rdy); end
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    doHandshake(22'd1000, 15'd4, ok);
    waitPixel(lat, ok);
    checks++; if (lat != EXP_LAT) begin fails++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, EXP_LAT); end
    checks++; if (pxl_data !== 8'd250) begin fails++; $display("[TB] FAIL basic_data: got %0d expected 250", pxl_data); end
    checks++; if (pxl_idx !== 6'(expIdx)) begin fails++; $display("[TB] FAIL basic_idx: got %0d expected %0d", pxl_idx, expIdx); end
    checks++; if (sum_rdy !== 1'b0) begin fails++; $display("[TB] FAIL basic_rdy_in_out: got %b expected 0", sum_rdy); end
    takePixel();
  endtask

  task automatic test_patterns();
    logic [21:0] sums [10] = '{22'd1003, 22'd12345, 22'd99, 22'd7, 22'd0,
                               22'd65535, 22'd65792, 22'd4194303, 22'd300000, 22'd300000};
    logic [14:0] szs  [10] = '{15'd4, 15'd100, 15'd100, 15'd2, 15'd5,
                               15'd257, 15'd257, 15'd1, 15'd1, 15'd32767};
    int expTr [10] = '{250, 123, 0, 3, 0, 255, 255, 255, 255, 9};
    int expRd [10] = '{251, 123, 1, 4, 0, 255, 255, 255, 255, 9};
    bit ok;
    int lat;
    int exp;
    for (int i = 0; i < 10; i++) begin
      doHandshake(sums[i], szs[i], ok);
      waitPixel(lat, ok);
      exp = ROUND ? expRd[i] : expTr[i];
      checks++; if (!ok) begin fails++; $display("[TB] FAIL pattern%0d_valid: got 0 expected 1", i); end
      checks++; if (pxl_data !== 8'(exp)) begin fails++; $display("[TB] FAIL pattern%0d_data: got %0d expected %0d", i, pxl_data, exp); end
      takePixel();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    int hold;
    doHandshake(22'd5000, 15'd20, ok);
    waitPixel(lat, ok);
    hold = expIdx;
    sum_vld = 1'b1; sum_data = 22'd77; blk_sz = 15'd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (pxl_vld !== 1'b1) begin fails++; $display("[TB] FAIL bp_vld%0d: got %b expected 1", i, pxl_vld); end
      checks++; if (pxl_data !== 8'd250) begin fails++; $display("[TB] FAIL bp_data%0d: got %0d expected 250", i, pxl_data); end
      checks++; if (pxl_idx !== 6'(hold)) begin fails++; $display("[TB] FAIL bp_idx%0d: got %0d expected %0d", i, pxl_idx, hold); end
      checks++; if (sum_rdy !== 1'b0) begin fails++; $display("[TB] FAIL bp_rdy%0d: got %b expected 0", i, sum_rdy); end
    end
    sum_vld = 1'b0;
    takePixel();
    checks++; if (pxl_vld !== 1'b0) begin fails++; $display("[TB] FAIL bp_single_pixel: got %b expected 0", pxl_vld); end
    checks++; if (pxl_idx !== 6'(expIdx)) begin fails++; $display("[TB] FAIL bp_idx_advance: got %0d expected %0d", pxl_idx, expIdx); end
  endtask

  task automatic test_div_zero();
    bit ok;
    int lat;
    checks++; if (dz_err !== 1'b0) begin fails++; $display("[TB] FAIL dz_before: got %b expected 0", dz_err); end
    doHandshake(22'd5, 15'd0, ok);
    waitPixel(lat, ok);
    checks++; if (lat >= EXP_LAT) begin fails++; $display("[TB] FAIL dz_skip_div: got latency %0d expected below %0d", lat, EXP_LAT); end
    checks++; if (pxl_data !== 8'd255) begin fails++; $display("[TB] FAIL dz_data: got %0d expected 255", pxl_data); end
    checks++; if (dz_err !== 1'b1) begin fails++; $display("[TB] FAIL dz_flag: got %b expected 1", dz_err); end
    takePixel();
    for (int i = 0; i < 2; i++) begin
      doHandshake(22'd1000, 15'd4, ok);
      waitPixel(lat, ok);
      checks++; if (pxl_data !== 8'd250) begin fails++; $display("[TB] FAIL dz_after_data%0d: got %0d expected 250", i, pxl_data); end
      checks++; if (dz_err !== 1'b1) begin fails++; $display("[TB] FAIL dz_sticky%0d: got %b expected 1", i, dz_err); end
      takePixel();
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lat;
    doReset();
    checks++; if (dz_err !== 1'b0) begin fails++; $display("[TB] FAIL b2b_dz_cleared: got %b expected 0", dz_err); end
    for (int i = 0; i < 65; i++) begin
      doHandshake(22'(i * 3), 15'd3, ok);
      waitPixel(lat, ok);
      checks++; if (pxl_idx !== 6'(i % 64)) begin fails++; $display("[TB] FAIL b2b_idx%0d: got %0d expected %0d", i, pxl_idx, i % 64); end
      checks++; if (pxl_last !== (i == 63)) begin fails++; $display("[TB] FAIL b2b_last%0d: got %b expected %b", i, pxl_last, (i == 63)); end
      checks++; if (pxl_data !== 8'(i)) begin fails++; $display("[TB] FAIL b2b_data%0d: got %0d expected %0d", i, pxl_data, i); end
      takePixel();
    end
  endtask

  task automatic test_reset_mid_div();
    bit ok;
    int lat;
    int rises;
    doHandshake(22'd800, 15'd8, ok);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #2;
    checks++; if (pxl_vld !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_vld: got %b expected 0", pxl_vld); end
    checks++; if (sum_rdy !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_rdy: got %b expected 0", sum_rdy); end
    checks++; if (pxl_data !== 8'd0) begin fails++; $display("[TB] FAIL mid_rst_data: got %0d expected 0", pxl_data); end
    checks++; if (pxl_idx !== 6'd0) begin fails++; $display("[TB] FAIL mid_rst_idx: got %0d expected 0", pxl_idx); end
    #2;
    rst_n = 1'b1;
    expIdx = 0;
    rises = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (pxl_vld) rises++;
    end
    checks++; if (rises != 0) begin fails++; $display("[TB] FAIL mid_rst_no_pixel: got %0d expected 0", rises); end
    doHandshake(22'd40, 15'd8, ok);
    waitPixel(lat, ok);
    checks++; if (pxl_idx !== 6'd0) begin fails++; $display("[TB] FAIL mid_rst_next_idx: got %0d expected 0", pxl_idx); end
    checks++; if (pxl_data !== 8'd5) begin fails++; $display("[TB] FAIL mid_rst_next_data: got %0d expected 5", pxl_data); end
    takePixel();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_backpressure();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
